modbus_rtu_req_tx: RTL and testbench

MODBUS_RTU_REQ_TX -- requirements
Module: modbus_rtu_req_tx

---
 rtl/modbus_rtu_req_tx.sv | 209 ++++++++++++++++++++
 tb/tb_modbus_rtu_req_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_req_tx.sv
// ============================================================================
// Module   : modbus_rtu_req_tx
// Purpose  : Serialises one Modbus RTU request (6 header bytes + CRC-16) onto
//            a UART line. The line then stays idle for the 3.5-character gap.
// Options  : MODBUS_REQ_TX_PARITY_EN adds an even-parity bit to each character
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modbus_rtu_req_tx (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [15:0] baud_div,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_slave,
  input  logic [7:0]  req_func,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        uart_tx_o,
  output logic        busy,
  output logic        done,
  output logic [15:0] crc_o
);

  localparam logic [15:0] c_CRC_INIT = 16'hFFFF;
  localparam logic [15:0] c_CRC_POLY = 16'hA001;
  localparam logic [2:0]  c_LAST_BIT = 3'd7;
  localparam logic [2:0]  c_LAST_BYTE = 3'd7;
  localparam logic [2:0]  c_CRC_BYTES = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
`ifdef MODBUS_REQ_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    GAP    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ready;
  logic [15:0] r_baud;
  logic [39:0] r_frame;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit;
  logic [2:0]  r_byte;
  logic [25:0] r_cnt;
  logic [15:0] r_crc;
`ifdef MODBUS_REQ_TX_PARITY_EN
  logic        r_par;
`endif

  logic        w_accept;
  logic [15:0] w_baud_eff;
  logic [19:0] w_bit_len;
  logic [25:0] w_bit_last;
  logic [25:0] w_gap_last;
  logic        w_bit_end;
  logic        w_gap_end;
  logic        w_cnt_wrap;
  logic [15:0] w_crc_step;
  logic [7:0]  w_next_byte;
  logic        w_tx;
  logic        w_done;

  assign w_accept   = req_valid && r_ready;
  assign w_baud_eff = (r_baud == 16'd0) ? 16'd1 : r_baud;
  assign w_bit_len  = {w_baud_eff, 4'b0000};
  assign w_bit_last = {6'd0, w_bit_len} - 26'd1;
  // 35 bit times = 32B + 2B + B
  assign w_gap_last = {1'b0, w_bit_len, 5'd0} + {5'd0, w_bit_len, 1'b0}
                    + {6'd0, w_bit_len} - 26'd1;
  assign w_bit_end  = (r_cnt == w_bit_last);
  assign w_gap_end  = (r_cnt == w_gap_last);
  assign w_cnt_wrap = (r_state == GAP) ? w_gap_end : w_bit_end;

  // CRC advances one bit per transmitted data bit, LSB first
  assign w_crc_step = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ r_shift[0]) ? c_CRC_POLY : 16'h0000);

  always_comb begin
    w_next_byte = 8'h00;
    case (r_byte)
      3'd0:    w_next_byte = r_frame[39:32];
      3'd1:    w_next_byte = r_frame[31:24];
      3'd2:    w_next_byte = r_frame[23:16];
      3'd3:    w_next_byte = r_frame[15:8];
      3'd4:    w_next_byte = r_frame[7:0];
      3'd5:    w_next_byte = r_crc[7:0];
      3'd6:    w_next_byte = r_crc[15:8];
      default: w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_next = DATA;
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end && (r_bit == c_LAST_BIT)) begin
`ifdef MODBUS_REQ_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef MODBUS_REQ_TX_PARITY_EN
      PARITY: begin
        w_tx = r_par;
        if (w_bit_end) w_next = STOP;
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (r_byte == c_LAST_BYTE) begin
            w_next = GAP;
            w_done = 1'b1;
          end else begin
            w_next = START;
          end
        end
      end
      GAP: begin
        if (w_gap_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_baud  <= 16'd0;
      r_frame <= 40'd0;
      r_shift <= 8'd0;
      r_bit   <= 3'd0;
      r_byte  <= 3'd0;
      r_cnt   <= 26'd0;
      r_crc   <= c_CRC_INIT;
`ifdef MODBUS_REQ_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE || w_cnt_wrap) begin
        r_cnt <= 26'd0;
      end else begin
        r_cnt <= r_cnt + 26'd1;
      end

      if (w_accept) begin
        r_baud  <= baud_div;
        r_frame <= {req_func, req_addr, req_data};
        r_shift <= req_slave;
        r_bit   <= 3'd0;
        r_byte  <= 3'd0;
        r_crc   <= c_CRC_INIT;
`ifdef MODBUS_REQ_TX_PARITY_EN
        r_par   <= ^req_slave;
`endif
      end

      if ((r_state == DATA) && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
        if (r_byte < c_CRC_BYTES) r_crc <= w_crc_step;
      end

      // CRC is complete by the end of byte 5, so bytes 6/7 read it directly
      if ((r_state == STOP) && w_bit_end && (r_byte != c_LAST_BYTE)) begin
        r_byte  <= r_byte + 3'd1;
        r_shift <= w_next_byte;
`ifdef MODBUS_REQ_TX_PARITY_EN
        r_par   <= ^w_next_byte;
`endif
      end
    end
  end

  assign req_ready = r_ready;
  assign busy      = ~r_ready;
  assign uart_tx_o = w_tx;
  assign done      = w_done;
  assign crc_o     = r_crc;

endmodule

`default_nettype wire

// File: tb/tb_modbus_rtu_req_tx.sv
// ============================================================================
// Module   : tb_modbus_rtu_req_tx
// Purpose  : Directed self-checking bench for modbus_rtu_req_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modbus_rtu_req_tx;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [15:0] baud_div;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_slave;
  logic [7:0]  req_func;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        uart_tx_o;
  logic        busy;
  logic        done;
  logic [15:0] crc_o;

`ifdef MODBUS_REQ_TX_PARITY_EN
  localparam int c_BPC = 11;
`else
  localparam int c_BPC = 10;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  modbus_rtu_req_tx u_dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .baud_div  (baud_div),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_slave (req_slave),
    .req_func  (req_func),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .uart_tx_o (uart_tx_o),
    .busy      (busy),
    .done      (done),
    .crc_o     (crc_o)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Presents a request at a falling edge; es is the cycle the start bit
  // should appear in if the block is idle.
  task automatic send_req(input logic [15:0] bd, input logic [7:0] sl, input logic [7:0] fn,
                          input logic [15:0] ad, input logic [15:0] dt, output int es);
    @(negedge PCLK);
    baud_div  = bd;
    req_slave = sl;
    req_func  = fn;
    req_addr  = ad;
    req_data  = dt;
    req_valid = 1'b1;
    es = cyc + 1;
  endtask

  // Finds the first start-bit cycle, then scrambles the request inputs.
  task automatic wait_start(input int limit, output int st);
    int n;
    n = 0;
    @(negedge PCLK);
    while (uart_tx_o !== 1'b0 && n < limit) begin
      @(negedge PCLK);
      n++;
    end
    st = cyc;
    if (uart_tx_o !== 1'b0) check("start_timeout", 32'(uart_tx_o), 32'd0);
    req_valid = 1'b0;
    req_slave = 8'h5A;
    req_func  = 8'hA5;
    req_addr  = 16'h1234;
    req_data  = 16'hBEEF;
    baud_div  = 16'd7;
  endtask

  task automatic rx_frame(input int bt, input logic [63:0] exp, input string tag,
                          output int st, output int dcyc);
    logic [10:0] bits;
    logic [7:0]  eb;
    logic        s0;
    int          glitch, fr_err, dcnt, didx;
    glitch = 0; fr_err = 0; dcnt = 0; didx = -1; dcyc = -1;
    bits = '0; s0 = 1'b1;
    wait_start(40 * bt + 64, st);
    for (int c = 0; c < 8; c++) begin
      eb = exp[63 - 8 * c -: 8];
      for (int j = 0; j < c_BPC; j++) begin
        for (int i = 0; i < bt; i++) begin
          if (c != 0 || j != 0 || i != 0) @(negedge PCLK);
          if (i == 0) s0 = uart_tx_o;
          else if (uart_tx_o !== s0) glitch++;
          if (done === 1'b1) begin
            dcnt++;
            didx = ((c * c_BPC + j) * bt) + i;
            dcyc = cyc;
          end else if (done !== 1'b0) begin
            dcnt++;
          end
        end
        bits[j] = s0;
      end
      check($sformatf("%s_byte%0d", tag, c), 32'(bits[8:1]), 32'(eb));
      if (bits[0] !== 1'b0 || bits[c_BPC - 1] !== 1'b1) fr_err++;
`ifdef MODBUS_REQ_TX_PARITY_EN
      check($sformatf("%s_par%0d", tag, c), 32'(bits[9]), 32'(^eb));
`endif
    end
    check({tag, "_framing"}, 32'(fr_err), 32'd0);
    check({tag, "_bit_stable"}, 32'(glitch), 32'd0);
    check({tag, "_done_count"}, 32'(dcnt), 32'd1);
    check({tag, "_done_pos"}, 32'(didx + 1), 32'(8 * c_BPC * bt));
  endtask

  initial begin
    int st, dc, st2, dc2, es, target, nd;
    PRESETn   = 1'b0;
    req_valid = 1'b0;
    baud_div  = 16'd0;
    req_slave = 8'd0;
    req_func  = 8'd0;
    req_addr  = 16'd0;
    req_data  = 16'd0;

    repeat (3) @(negedge PCLK);
    check("rst_tx",    32'(uart_tx_o), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy",  32'(busy),      32'd1);
    check("rst_done",  32'(done),      32'd0);
    check("rst_crc",   32'(crc_o),     32'h0000FFFF);
    PRESETn = 1'b1;
    #1 check("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge PCLK);
    #1 check("ready_first_edge", 32'(req_ready), 32'd1);

    // Write single coil at baud_div=54
    send_req(16'd54, 8'h01, 8'h05, 16'h0000, 16'hFF00, es);
    rx_frame(864, 64'h01050000FF008C3A, "wc", st, dc);
    check("wc_start", 32'(st), 32'(es));
    @(negedge PCLK);
    check("gap_busy",  32'(busy),      32'd1);
    check("gap_ready", 32'(req_ready), 32'd0);
    check("gap_tx",    32'(uart_tx_o), 32'd1);
    check("wc_crc",    32'(crc_o),     32'h00003A8C);
    PRESETn = 1'b0;
    #1 check("gap_abort_crc", 32'(crc_o), 32'h0000FFFF);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;

    // Read coils, then read DI held pending through the gap
    send_req(16'd1, 8'h01, 8'h01, 16'h0000, 16'h0001, es);
    rx_frame(16, 64'h01010000_0001FDCA, "rc", st, dc);
    check("rc_start", 32'(st), 32'(es));
    check("rc_crc", 32'(crc_o), 32'h0000CAFD);
    send_req(16'd1, 8'h01, 8'h02, 16'h0000, 16'h0001, es);
    check("pend_ready", 32'(req_ready), 32'd0);
    rx_frame(16, 64'h01020000_0001B9CA, "di", st2, dc2);
    check("b2b_gap", 32'(st2 - (dc + 1)), 32'(35 * 16 + 1));
    check("di_crc", 32'(crc_o), 32'h0000CAB9);

    // Reset in byte 3, data bit 4
    send_req(16'd1, 8'h01, 8'h03, 16'h0000, 16'h000A, es);
    wait_start(40 * 16 + 64, st);
    target = st + (3 * c_BPC + 5) * 16 + 8;
    while (cyc < target) @(negedge PCLK);
    check("mid_bit", 32'(uart_tx_o), 32'd0);
    PRESETn = 1'b0;
    #1;
    check("abort_tx",    32'(uart_tx_o), 32'd1);
    check("abort_done",  32'(done),      32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    nd = 0;
    repeat (4) begin
      @(negedge PCLK);
      if (done !== 1'b0) nd++;
    end
    PRESETn = 1'b1;
    repeat (100) begin
      @(negedge PCLK);
      if (done !== 1'b0) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    check("abort_idle", 32'(req_ready), 32'd1);

    // baud_div=0 behaves as 1
    send_req(16'd0, 8'h01, 8'h05, 16'h0000, 16'hFF00, es);
    rx_frame(16, 64'h01050000FF008C3A, "bd0", st, dc);
    check("bd0_start", 32'(st), 32'(es));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
